and_tree_pipe: RTL and testbench
================================

Name: and_tree_pipe

Overview:
- Parametrised, pipelined N-input reduction gate. It is the successor to the fixed 4-input AND built from 2-input nand/nor cells.
- Reduces an N-bit input vector with a per-transaction selectable function: AND, NAND, OR or NOR.
- Pipeline registers are inserted every REG_EVERY tree levels, and a valid bit travels alongside the data.
- Used by verilog-to-layout generated datapaths for wide match/zero-detect logic, where an unregistered deep tree would break timing.

Parameters:
- N, 8, number of input bits; legal range 1..64.
- REG_EVERY, 2, number of 2-input tree levels between pipeline registers; legal range 1..6.
- LEVELS, derived = ceil(log2(N)) (0 when N=1); localparam, not overridable.
- LAT, derived = max(1, ceil(LEVELS/REG_EVERY)); latency in cycles; localparam.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  pipeline advance; 0 = every pipeline register holds.
- FLUSH  input  1  synchronous clear of all in-flight valid bits.
- IN_VALID  input  1  A/OP carry a transaction this cycle.
- OP  input  2  function select: 00 AND, 01 NAND, 10 OR, 11 NOR.
- A  input  N  operand vector.
- OUT_VALID  output  1  O carries a completed transaction result.
- OUT_OP  output  2  OP of the transaction presented on O.
- O  output  1  reduction result.

Behaviour:
- Reset (async, RST=1): every pipeline register clears immediately, including valid, op and partial results. O=0, OUT_VALID=0, OUT_OP=00.
  - Reset mid-operation discards all in-flight transactions; nothing is emitted after RST deasserts until new IN_VALID input.
- Tree structure: balanced 2-input tree of LEVELS levels.
  - Each level reduces with the base function (AND for OP[1]=0, OR for OP[1]=1).
  - The base function is selected by the OP bits registered alongside the data at that stage.
  - Odd/unused leaves are padded with the identity value: 1 for AND, 0 for OR.
- Inversion: applied once, at the final output register, when OP[0]=1.
- Register placement: stage k (k=1..LAT) registers the partial vector after levels ((k-1)*REG_EVERY+1)..min(k*REG_EVERY, LEVELS).
  - The final stage is always registered, so O is always a flop output.
  - N=1 gives LAT=1, and O is the registered A[0], optionally inverted.
- Latency: with EN held 1, a transaction accepted at edge t appears on O/OUT_VALID/OUT_OP after edge t+LAT-1, i.e. LAT cycles after it is presented.
  - Throughput: one transaction per cycle; no back-pressure output.
- EN=0: every stage register (data, op, valid) holds; input is ignored that cycle; outputs hold their values.
- Data registers load whenever EN=1, independent of IN_VALID. O and OUT_OP are meaningful only while OUT_VALID=1.
- FLUSH=1 at an edge: all valid bits clear to 0, regardless of EN, and the IN_VALID of that cycle is dropped. Data registers still follow EN.
- Simultaneous events:
  - FLUSH and EN both 1: FLUSH wins for valid bits.
  - RST overrides everything.
- Bubbles (IN_VALID=0) propagate as OUT_VALID=0 in their slot; ordering is strictly preserved.

Decomposition:
- Shared package and_tree_pkg holds:
  - OP encodings OP_AND=2'b00, OP_NAND=2'b01, OP_OR=2'b10, OP_NOR=2'b11;
  - function clog2;
  - function lat_of(N, REG_EVERY).
- Sub-module and_tree_stage holds one registered stage:
  - parameters IN_W and NLEV;
  - inputs: partial vector, op, valid, EN, FLUSH;
  - does identity padding, the NLEV combinational 2-input levels, and the register.
- and_tree_pipe instantiates LAT of these in a generate loop, then applies the final OP[0] inversion at the last stage.

Test Plan:
- Reset and latency: N=8, REG_EVERY=2 (LAT=2). A=8'hFF, OP=AND, IN_VALID=1 for one cycle -> OUT_VALID=1 and O=1 exactly 2 cycles later; all outputs 0 while RST=1.
- Mode sweep, back-to-back, same config, four consecutive cycles:
  - A=8'hFE, AND -> O=0.
  - A=8'hFE, NAND -> O=1.
  - A=8'h00, OR -> O=0.
  - A=8'h00, NOR -> O=1.
  - Four consecutive OUT_VALID results, OUT_OP matching in order.
- Padding: N=5, REG_EVERY=1 (LAT=3). A=5'h1F, AND -> O=1; A=5'h00, OR -> O=0; each after 3 cycles (pad bits must not corrupt).
- Stall: issue A=8'hFF AND, then hold EN=0 for 3 cycles mid-flight -> result appears 3 cycles late, exactly once, and outputs hold during the stall.
- Flush and reset:
  - Two valid transactions in flight, then FLUSH=1 with IN_VALID=1 -> no OUT_VALID for the flushed items or the dropped input.
  - Repeat using RST asserted mid-cycle (async) -> outputs clear before the next CLK edge.
- Degenerate: N=1, REG_EVERY=1. A=1, NOR -> O=0 after 1 cycle; A=0, NAND -> O=1.

Source files
------------

// File: rtl/and_tree_pkg.sv
// Shared encodings and elaboration-time helpers for the pipelined reduction tree.
package and_tree_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Number of surviving tree nodes after lev 2-input levels applied to n leaves.
    function automatic int width_at(input int n, input int lev);
        return ((n - 1) >> lev) + 1;
    endfunction

    function automatic int lat_of(input int n, input int reg_every);
        int s;
        s = (clog2(n) + reg_every - 1) / reg_every;
        return (s < 1) ? 1 : s;
    endfunction

endpackage

// File: rtl/and_tree_stage.sv
// One registered slice of the reduction tree: pad to a power-of-two group size,
// reduce NLEV levels with the op-selected base function, then register.
module and_tree_stage
    import and_tree_pkg::*;
#(
    parameter int IN_W    = 2,
    parameter int NLEV    = 1,
    parameter bit INV_OUT = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              flush,
    input  logic [IN_W-1:0]                   vec_i,
    input  logic [1:0]                        op_i,
    input  logic                              vld_i,
    output logic [width_at(IN_W, NLEV)-1:0]   vec_o,
    output logic [1:0]                        op_o,
    output logic                              vld_o
);

    localparam int OUT_W = width_at(IN_W, NLEV);
    localparam int PAD_W = OUT_W << NLEV;

    logic [PAD_W-1:0] work;
    logic [OUT_W-1:0] vec_d, vec_q;
    logic [1:0]       op_d, op_q;
    logic             vld_d, vld_q;

    always_comb begin
        // Identity fill: 1 for AND-family, 0 for OR-family.
        work = {PAD_W{~op_i[1]}};
        work[IN_W-1:0] = vec_i;
        // In-place reduction: node i only reads 2i/2i+1, never an already-updated slot.
        for (int l = 0; l < NLEV; l++) begin
            for (int i = 0; i < (PAD_W >> (l + 1)); i++) begin
                work[i] = op_i[1] ? (work[2*i] | work[2*i+1]) : (work[2*i] & work[2*i+1]);
            end
        end

        vec_d = vec_q;
        op_d  = op_q;
        if (en) begin
            vec_d = work[OUT_W-1:0] ^ {OUT_W{INV_OUT && op_i[0]}};
            op_d  = op_i;
        end

        vld_d = vld_q;
        if (flush)   vld_d = 1'b0;
        else if (en) vld_d = vld_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q <= '0;
            op_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            vec_q <= vec_d;
            op_q  <= op_d;
            vld_q <= vld_d;
        end
    end

    assign vec_o = vec_q;
    assign op_o  = op_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/and_tree_pipe.sv
// Pipelined N-input AND/NAND/OR/NOR reduction with a registered stage every
// REG_EVERY tree levels; op and valid travel with the partial vector.
module and_tree_pipe
    import and_tree_pkg::*;
#(
    parameter int N         = 8,
    parameter int REG_EVERY = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         FLUSH,
    input  logic         IN_VALID,
    input  logic [1:0]   OP,
    input  logic [N-1:0] A,
    output logic         OUT_VALID,
    output logic [1:0]   OUT_OP,
    output logic         O
);

    localparam int LEVELS = clog2(N);
    localparam int LAT    = lat_of(N, REG_EVERY);

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int REM = LEVELS - k * REG_EVERY;
        localparam int NL  = (REM < REG_EVERY) ? REM : REG_EVERY;
        localparam int IW  = width_at(N, k * REG_EVERY);
        localparam int OW  = width_at(IW, NL);

        logic [IW-1:0] vec_i;
        logic [1:0]    op_i;
        logic          vld_i;
        logic [OW-1:0] vec_o;
        logic [1:0]    op_o;
        logic          vld_o;

        if (k == 0) begin : g_head
            assign vec_i = A;
            assign op_i  = OP;
            assign vld_i = IN_VALID;
        end else begin : g_link
            assign vec_i = g_stage[k-1].vec_o;
            assign op_i  = g_stage[k-1].op_o;
            assign vld_i = g_stage[k-1].vld_o;
        end

        // Only the last stage inverts, so O stays a plain flop output.
        and_tree_stage #(
            .IN_W    (IW),
            .NLEV    (NL),
            .INV_OUT (k == LAT - 1)
        ) u_stage (
            .clk   (CLK),
            .rst   (RST),
            .en    (EN),
            .flush (FLUSH),
            .vec_i (vec_i),
            .op_i  (op_i),
            .vld_i (vld_i),
            .vec_o (vec_o),
            .op_o  (op_o),
            .vld_o (vld_o)
        );
    end

    assign O         = g_stage[LAT-1].vec_o[0];
    assign OUT_OP    = g_stage[LAT-1].op_o;
    assign OUT_VALID = g_stage[LAT-1].vld_o;

endmodule

// File: tb/tb_and_tree_pipe.sv
// Directed bench for and_tree_pipe: three configurations (8/2, 5/1, 1/1) share
// the control inputs; each test checks only the instance it targets.
module tb_and_tree_pipe;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic [1:0] op;
    logic [7:0] a8;
    logic [4:0] a5;
    logic [0:0] a1;

    logic       v8, v5, v1;
    logic [1:0] op8, op5, op1;
    logic       o8, o5, o1;

    int n_run  = 0;
    int n_fail = 0;

    and_tree_pipe #(.N(8), .REG_EVERY(2)) u8 (
        .CLK(clk), .RST(rst), .EN(en), .FLUSH(flush), .IN_VALID(in_valid), .OP(op), .A(a8),
        .OUT_VALID(v8), .OUT_OP(op8), .O(o8));
    and_tree_pipe #(.N(5), .REG_EVERY(1)) u5 (
        .CLK(clk), .RST(rst), .EN(en), .FLUSH(flush), .IN_VALID(in_valid), .OP(op), .A(a5),
        .OUT_VALID(v5), .OUT_OP(op5), .O(o5));
    and_tree_pipe #(.N(1), .REG_EVERY(1)) u1 (
        .CLK(clk), .RST(rst), .EN(en), .FLUSH(flush), .IN_VALID(in_valid), .OP(op), .A(a1),
        .OUT_VALID(v1), .OUT_OP(op1), .O(o1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [7:0] a);
        in_valid = v;
        op       = o;
        a8       = a;
        a5       = a[4:0];
        a1       = a[0:0];
    endtask

    task automatic idle(input int n);
        drive(1'b0, 2'b00, 8'h00);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [1:0] sw_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] sw_a   [4] = '{8'hFE, 8'hFE, 8'h00, 8'h00};
    logic       sw_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        drive(1'b1, 2'b11, 8'hFF);
        step(); step();
        chk("rst_v8", {7'b0, v8}, 8'h0);
        chk("rst_o8", {7'b0, o8}, 8'h0);
        chk("rst_op8", {6'b0, op8}, 8'h0);
        chk("rst_v5", {7'b0, v5}, 8'h0);
        chk("rst_v1", {7'b0, v1}, 8'h0);
        rst = 1'b0;
        idle(1);

        // latency: LAT=2 for 8/2
        drive(1'b1, 2'b00, 8'hFF);
        step();
        drive(1'b0, 2'b00, 8'h00);
        chk("lat_early_v", {7'b0, v8}, 8'h0);
        step();
        chk("lat_v", {7'b0, v8}, 8'h1);
        chk("lat_o", {7'b0, o8}, 8'h1);
        chk("lat_op", {6'b0, op8}, 8'h0);
        step();
        chk("lat_once", {7'b0, v8}, 8'h0);
        idle(3);

        // back-to-back mode sweep
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, sw_op[i], sw_a[i]);
            else       drive(1'b0, 2'b00, 8'h00);
            step();
            if (i >= 1 && i <= 4) begin
                chk($sformatf("sweep_v%0d", i - 1), {7'b0, v8}, 8'h1);
                chk($sformatf("sweep_o%0d", i - 1), {7'b0, o8}, {7'b0, sw_exp[i-1]});
                chk($sformatf("sweep_op%0d", i - 1), {6'b0, op8}, {6'b0, sw_op[i-1]});
            end else if (i == 5) begin
                chk("sweep_end_v", {7'b0, v8}, 8'h0);
            end
        end
        idle(4);

        // padding on N=5, LAT=3
        drive(1'b1, 2'b00, 8'h1F); step();
        drive(1'b1, 2'b10, 8'h00); step();
        drive(1'b1, 2'b10, 8'h10); step();
        chk("pad_and_v", {7'b0, v5}, 8'h1);
        chk("pad_and_o", {7'b0, o5}, 8'h1);
        drive(1'b1, 2'b00, 8'h0F); step();
        chk("pad_or0_v", {7'b0, v5}, 8'h1);
        chk("pad_or0_o", {7'b0, o5}, 8'h0);
        chk("pad_or0_op", {6'b0, op5}, 8'h2);
        drive(1'b0, 2'b00, 8'h00); step();
        chk("pad_or_hi_o", {7'b0, o5}, 8'h1);
        step();
        chk("pad_and_lo_o", {7'b0, o5}, 8'h0);
        step();
        chk("pad_end_v", {7'b0, v5}, 8'h0);
        idle(4);

        // stall on 8/2: NAND result held on output while EN=0
        drive(1'b1, 2'b01, 8'hFE); step();
        drive(1'b1, 2'b00, 8'hFE); step();
        chk("stall_pre_o", {7'b0, o8}, 8'h1);
        en = 1'b0;
        drive(1'b1, 2'b10, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_hold_v%0d", i), {7'b0, v8}, 8'h1);
            chk($sformatf("stall_hold_o%0d", i), {7'b0, o8}, 8'h1);
            chk($sformatf("stall_hold_op%0d", i), {6'b0, op8}, 8'h1);
        end
        en = 1'b1;
        drive(1'b0, 2'b00, 8'h00);
        step();
        chk("stall_res_v", {7'b0, v8}, 8'h1);
        chk("stall_res_o", {7'b0, o8}, 8'h0);
        chk("stall_res_op", {6'b0, op8}, 8'h0);
        step();
        chk("stall_once", {7'b0, v8}, 8'h0);
        idle(4);

        // flush with two in flight on 5/1 plus a dropped input
        drive(1'b1, 2'b00, 8'h1F); step();
        drive(1'b1, 2'b00, 8'h1F); step();
        flush = 1'b1;
        drive(1'b1, 2'b00, 8'h1F); step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("flush_v%0d", i), {7'b0, v5}, 8'h0);
            step();
        end
        idle(2);

        // async reset mid-cycle
        drive(1'b1, 2'b11, 8'h00); step();
        drive(1'b1, 2'b11, 8'h00); step();
        drive(1'b0, 2'b00, 8'h00);
        chk("arst_pre_v", {7'b0, v8}, 8'h1);
        chk("arst_pre_o", {7'b0, o8}, 8'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_v", {7'b0, v8}, 8'h0);
        chk("arst_o", {7'b0, o8}, 8'h0);
        chk("arst_op", {6'b0, op8}, 8'h0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("arst_post_v5_%0d", i), {7'b0, v5}, 8'h0);
            chk($sformatf("arst_post_v8_%0d", i), {7'b0, v8}, 8'h0);
        end
        idle(2);

        // degenerate N=1
        drive(1'b1, 2'b11, 8'h01); step();
        chk("n1_nor_v", {7'b0, v1}, 8'h1);
        chk("n1_nor_o", {7'b0, o1}, 8'h0);
        chk("n1_nor_op", {6'b0, op1}, 8'h3);
        drive(1'b1, 2'b01, 8'h00); step();
        chk("n1_nand_o", {7'b0, o1}, 8'h1);
        chk("n1_nand_op", {6'b0, op1}, 8'h1);
        drive(1'b0, 2'b00, 8'h00); step();
        chk("n1_end_v", {7'b0, v1}, 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
